// File: rtl/demux_tdm_bus_prm.sv
// Time-division bus demultiplexer: collects 2**SEL_WIDTH serial words framed by sof_i
// into one parallel registered frame, with ready/valid handshakes on both sides.
module demux_tdm_bus_prm #(
    parameter int SEL_WIDTH = 2,
    parameter int DAT_WIDTH = 2
) (
    input  logic                                       clk_i,
    input  logic                                       rst_n_i,
    input  logic [DAT_WIDTH-1:0]                       dat_i,
    input  logic                                       vld_i,
    input  logic                                       sof_i,
    output logic                                       rdy_o,
    output logic [2**SEL_WIDTH-1:0][DAT_WIDTH-1:0]     dat_o,
    output logic                                       vld_o,
    input  logic                                       rdy_i,
    output logic [SEL_WIDTH-1:0]                       sel_o,
    output logic                                       err_o
);

    localparam int N = 2**SEL_WIDTH;
    localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(N - 1);
    localparam logic [SEL_WIDTH-1:0] ONE_IDX  = SEL_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                                 state_q, state_d;
    logic [SEL_WIDTH-1:0]                   idx_q, idx_d;
    logic [N-1:0][DAT_WIDTH-1:0]            dat_q, dat_d;
    logic                                   vld_q, vld_d;
    logic                                   err_q, err_d;
    logic                                   beat_in;
    logic                                   beat_out;

    // rdy_o is combinational so it drops immediately while reset is held
    assign rdy_o    = rst_n_i && ((state_q == IDLE) || (state_q == FILL));
    assign beat_in  = vld_i && rdy_o;
    assign beat_out = vld_q && rdy_i;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dat_d   = dat_q;
        vld_d   = vld_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (beat_in) begin
                    if (sof_i) begin
                        dat_d[0] = dat_i;
                        idx_d    = ONE_IDX;
                        state_d  = FILL;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            FILL: begin
                if (beat_in) begin
                    if (sof_i) begin
                        // resync: restart the frame at lane 0, flag the lost partial frame
                        dat_d[0] = dat_i;
                        idx_d    = ONE_IDX;
                        err_d    = 1'b1;
                    end else begin
                        dat_d[idx_q] = dat_i;
                        if (idx_q == LAST_IDX) begin
                            idx_d   = '0;
                            vld_d   = 1'b1;
                            state_d = HOLD;
                        end else begin
                            idx_d = idx_q + ONE_IDX;
                        end
                    end
                end
            end
            HOLD: begin
                if (beat_out) begin
                    vld_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                vld_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            dat_q   <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dat_q   <= dat_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    assign dat_o = dat_q;
    assign vld_o = vld_q;
    assign sel_o = idx_q;
    assign err_o = err_q;

endmodule

// File: tb/tb_demux_tdm_bus_prm.sv
// Directed bench for demux_tdm_bus_prm with SEL_WIDTH=2, DAT_WIDTH=4 (four 4-bit lanes).
module tb_demux_tdm_bus_prm;

    logic                 clk_i = 1'b0;
    logic                 rst_n_i = 1'b0;
    logic [3:0]           dat_i = '0;
    logic                 vld_i = 1'b0;
    logic                 sof_i = 1'b0;
    logic                 rdy_o;
    logic [3:0][3:0]      dat_o;
    logic                 vld_o;
    logic                 rdy_i = 1'b0;
    logic [1:0]           sel_o;
    logic                 err_o;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    demux_tdm_bus_prm #(.SEL_WIDTH(2), .DAT_WIDTH(4)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .dat_i   (dat_i),
        .vld_i   (vld_i),
        .sof_i   (sof_i),
        .rdy_o   (rdy_o),
        .dat_o   (dat_o),
        .vld_o   (vld_o),
        .rdy_i   (rdy_i),
        .sel_o   (sel_o),
        .err_o   (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // one accepted input beat; outputs are sampled 1 time unit after the edge
    task automatic beat(input logic [3:0] d, input logic s);
        dat_i = d;
        sof_i = s;
        vld_i = 1'b1;
        tick();
        vld_i = 1'b0;
        sof_i = 1'b0;
    endtask

    initial begin
        // 1: reset held with vld_i high
        rst_n_i = 1'b0;
        vld_i = 1'b1; sof_i = 1'b1; dat_i = 4'h5;
        repeat (3) tick();
        chk("rst_rdy", rdy_o, 0);
        chk("rst_vld", vld_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_sel", sel_o, 0);
        chk("rst_dat", dat_o, 16'h0000);
        vld_i = 1'b0; sof_i = 1'b0;
        rst_n_i = 1'b1;
        #1;
        chk("rel_rdy", rdy_o, 1);

        // 2: back-to-back frame with downstream ready
        rdy_i = 1'b1;
        beat(4'hA, 1'b1); chk("s2_sel1", sel_o, 1);
        beat(4'hB, 1'b0); chk("s2_sel2", sel_o, 2);
        beat(4'hC, 1'b0); chk("s2_sel3", sel_o, 3); chk("s2_vld_early", vld_o, 0);
        beat(4'hD, 1'b0);
        chk("s2_sel0", sel_o, 0);
        chk("s2_vld", vld_o, 1);
        chk("s2_dat", dat_o, 16'hDCBA);
        chk("s2_rdy_hold", rdy_o, 0);
        tick();
        chk("s2_vld_fall", vld_o, 0);
        chk("s2_rdy_back", rdy_o, 1);

        // 3: backpressure while new words are offered
        rdy_i = 1'b0;
        beat(4'h1, 1'b1);
        beat(4'h2, 1'b0);
        beat(4'h3, 1'b0);
        beat(4'h4, 1'b0);
        vld_i = 1'b1; sof_i = 1'b1; dat_i = 4'h9;
        for (int i = 0; i < 5; i++) begin
            chk("s3_dat", dat_o, 16'h4321);
            chk("s3_vld", vld_o, 1);
            chk("s3_rdy", rdy_o, 0);
            chk("s3_err", err_o, 0);
            tick();
        end
        vld_i = 1'b0; sof_i = 1'b0;
        rdy_i = 1'b1;
        tick();
        chk("s3_vld_fall", vld_o, 0);

        // 4: two words without sof in IDLE, then a clean frame
        beat(4'h7, 1'b0); chk("s4_err1", err_o, 1);
        beat(4'h8, 1'b0); chk("s4_err2", err_o, 1);
        beat(4'h5, 1'b1); chk("s4_err_off", err_o, 0); chk("s4_sel", sel_o, 1);
        beat(4'h6, 1'b0); chk("s4_err_off2", err_o, 0);
        beat(4'h7, 1'b0);
        beat(4'h8, 1'b0);
        chk("s4_vld", vld_o, 1);
        chk("s4_dat", dat_o, 16'h8765);
        tick();
        chk("s4_vld_fall", vld_o, 0);

        // 5: resync in the middle of a frame
        beat(4'h1, 1'b1);
        beat(4'h2, 1'b0); chk("s5_err_pre", err_o, 0);
        beat(4'h9, 1'b1); chk("s5_err", err_o, 1); chk("s5_sel", sel_o, 1); chk("s5_vld0", vld_o, 0);
        beat(4'hA, 1'b0); chk("s5_err_off", err_o, 0); chk("s5_vld1", vld_o, 0);
        beat(4'hB, 1'b0); chk("s5_vld2", vld_o, 0);
        beat(4'hC, 1'b0);
        chk("s5_vld", vld_o, 1);
        chk("s5_dat", dat_o, 16'hCBA9);
        tick();
        chk("s5_vld_fall", vld_o, 0);
        tick();
        chk("s5_vld_once", vld_o, 0);

        // 6: reset mid-frame, then a full frame
        beat(4'h1, 1'b1);
        beat(4'h2, 1'b0);
        beat(4'h3, 1'b0);
        rst_n_i = 1'b0;
        tick();
        chk("s6_rst_vld", vld_o, 0);
        chk("s6_rst_sel", sel_o, 0);
        chk("s6_rst_err", err_o, 0);
        chk("s6_rst_rdy", rdy_o, 0);
        rst_n_i = 1'b1;
        beat(4'hE, 1'b1); chk("s6_vld0", vld_o, 0); chk("s6_err0", err_o, 0);
        beat(4'hF, 1'b0); chk("s6_vld1", vld_o, 0);
        beat(4'h0, 1'b0); chk("s6_vld2", vld_o, 0);
        beat(4'h1, 1'b0);
        chk("s6_vld", vld_o, 1);
        chk("s6_dat", dat_o, 16'h10FE);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
